cacheline_adaptor: RTL

Memory-side responder for the cache's line interface. Accepts a 256-bit line read or write request from the instruction/data cache (`pmem_read`/`pmem_write`, `pmem_address`, `pmem_rdata`/`pmem_wdata`, `pmem_resp`) and converts it into a burst of 64-bit beats on the physical-memory port. It collects read beats into a full line, or serializes a write line into beats, then returns a single-cycle completion to the cache. It sits between the cache datapath/control and physical memory.

---
 rtl/cacheline_adaptor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//
// Memory-side responder for the cache's line interface. A full cache line
// read or write request is turned into a burst of narrower beats on the
// physical-memory port: read beats are gathered into a line, a write line is
// serialized into beats, and a single-cycle completion pulse is returned to
// the cache when the burst is finished.
//
// Ports
//   clk            single clock, rising-edge active
//   rst            asynchronous, active-low reset
//   pmem_read      cache requests a line read
//   pmem_write     cache requests a line write (wins over a simultaneous read)
//   pmem_address   line address from the cache
//   pmem_wdata     write line from the cache
//   pmem_rdata     assembled read line, valid while pmem_resp=1 after a read
//   pmem_resp      one-cycle completion pulse to the cache
//   burst_address  line-aligned burst address, latched when a request is taken
//   burst_read     memory read burst in progress
//   burst_write    memory write burst in progress
//   burst_wdata    current write beat
//   burst_rdata    read beat from memory
//   burst_resp     memory accepts or delivers one beat this cycle
//
// Every output comes from a register or is decoded from state and registers,
// so there is no combinational path from any input to any output.

module cacheline_adaptor #(
  parameter int s_line = 256,
  parameter int s_beat = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_wdata,
  output logic [s_line-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [31:0]       burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [s_beat-1:0] burst_wdata,
  input  logic [s_beat-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int beats = s_line / s_beat;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  // Byte-offset bits of a line address; these are forced to zero.
  localparam int off_w = $clog2(s_line / 8);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [cnt_w-1:0]         cnt;
  logic [31:0]              addr_q;
  logic [s_line-1:0]        wline_q;
  logic [s_line-1:0]        rline_q;
  // Holds all read beats except the last one; the last beat goes straight
  // from burst_rdata into rline_q so the line is complete in the DONE cycle.
  logic [s_line-s_beat-1:0] asm_q;

  logic in_burst;
  logic beat_ok;
  logic last_ok;
  logic take_req;

  // The low address bits are discarded by line alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[off_w-1:0];

  assign in_burst = (state == READ) || (state == WRITE);
  assign beat_ok  = in_burst && burst_resp;
  assign last_ok  = beat_ok && (cnt == last_beat);
  assign take_req = (state == IDLE) && (pmem_read || pmem_write);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pmem_write)     state_nxt = WRITE;
        else if (pmem_read) state_nxt = READ;
      end
      READ, WRITE: begin
        if (last_ok) state_nxt = DONE;
      end
      // Requests are not sampled here, so a request the cache still holds
      // during the pmem_resp cycle cannot be accepted a second time.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and beat counter
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) cnt <= '0;
      else if (beat_ok)  cnt <= cnt + cnt_w'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Output-visible data registers
  // ---------------------------------------------------------------------
  // NOTE: these wide data registers carry a reset only because they drive
  // outputs that must read zero during reset; asm_q below is never visible
  // and is deliberately left without one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      if (take_req) addr_q <= {pmem_address[31:off_w], off_w'(0)};
      if ((state == IDLE) && pmem_write) wline_q <= pmem_wdata;
      // The assembled line only changes when a read completes, so the
      // previous line stays stable through writes and partial reads.
      if ((state == READ) && last_ok) rline_q <= {burst_rdata, asm_q};
    end
  end

  // Beat assembly: beat i lands in bits [i*s_beat +: s_beat].
  always_ff @(posedge clk) begin
    if ((state == READ) && burst_resp) begin
      for (int i = 0; i < beats - 1; i++) begin
        if (int'(cnt) == i) asm_q[i*s_beat +: s_beat] <= burst_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign pmem_resp     = (state == DONE);
  assign burst_address = addr_q;
  assign pmem_rdata    = rline_q;
  // cnt is held during stalls, so the current beat stays on the bus.
  assign burst_wdata   = wline_q[int'(cnt)*s_beat +: s_beat];

endmodule
